tea_cipher_apb: RTL and testbench
=================================

Name: tea_cipher_apb

Overview:
- Parametrised successor to the separate fixed-function TEA encrypt and decrypt engines.
- One iterative core performs either encryption or decryption, selected at run time.
- Key, input block, round count, mode and start are all programmed over APB; the result and status are read back over APB.
- Runs entirely in the pclk domain, with a done interrupt to the system interrupt controller.

Parameters:
- W, 16, half-block width in bits; legal values 8 or 16; block = 2W bits, key = 4W bits.
- DELTA, 16'h0123, round constant, truncated to W bits.
- SHL, 4, left shift in the round function.
- SHR, 5, logical right shift in the round function.
- RW, 8, width of the round-count field.

Ports:
- pclk  in  1  APB and core clock, rising edge.
- prstb  in  1  reset; asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  APB write.
- paddr  in  32  APB byte address; bits [4:2] decoded.
- pwdata  in  32  APB write data.
- prdata  out  32  APB read data.
- pready  out  1  tied to 1.
- pslverr  out  1  APB error response.
- irq  out  1  level interrupt = done & ien.

Behaviour:
- APB access: a transfer completes on the pclk edge where psel & penable are high. Reads are combinational from registers; zero wait states.
- Register map:
  - 0x00 KEY_LO RW = key[31:0].
  - 0x04 KEY_HI RW = key[63:32]; for W=8 it reads 0 and writes are ignored.
  - 0x08 DIN RW = block[2W-1:0].
  - 0x0C CTRL: [RW-1:0] rounds R; [RW] mode (0 = enc, 1 = dec); [RW+1] start, write-only, reads 0; [RW+2] ien.
  - 0x10 DOUT RO.
  - 0x14 STATUS: [0] busy RO; [1] done W1C; [2] err W1C.
- Unmapped address: pslverr=1, no side effects, prdata=0.
- Reset values: all registers 0, busy=0, done=0, err=0, irq=0, prdata=0, pslverr=0.
- Word and key layout:
  - v0 = block[2W-1:W], v1 = block[W-1:0].
  - k0 = key[4W-1:3W], k1 = key[3W-1:2W], k2 = key[2W-1:W], k3 = key[W-1:0].
- Round function: F(x,ka,kb,s) = ((x<<SHL)+ka) ^ (x+s) ^ ((x>>SHR)+kb). All arithmetic is mod 2^W.
- FSM states IDLE, RUN, DONE.
  - IDLE: a CTRL write with start=1 captures R and mode.
    - R != 0: load v0/v1 from DIN; sum = 0 for enc, (DELTA*R) mod 2^W for dec; cnt = R; busy=1; go to RUN.
    - R = 0: DOUT <= DIN on the same edge; done=1; stay in IDLE; busy never rises.
  - RUN (one round per pclk, two half-updates chained in one cycle):
    - enc: s = sum+DELTA; v0 += F(v1,k0,k1,s); v1 += F(v0new,k2,k3,s); sum = s.
    - dec: v1 -= F(v0,k2,k3,sum); v0 -= F(v1new,k0,k1,sum); sum -= DELTA.
    - cnt decrements each round. On the edge performing the last round: DOUT <= {v0,v1}, busy=0, done=1, go to DONE.
  - DONE: transitions to IDLE on the next edge. A start arriving in DONE is accepted as if in IDLE.
- Latency: DOUT is valid exactly R edges after the start-write edge; busy is high for exactly R cycles.
- Writes while busy:
  - Writes to KEY_LO, KEY_HI, DIN or CTRL are ignored, return pslverr=1 and set err.
  - Exception: a write to CTRL.ien is always taken, while start is ignored.
  - STATUS W1C writes are always accepted.
- Simultaneous events:
  - Completion and a W1C of done on the same edge: done ends up 1.
  - Completion and a W1C of err on the same edge: err is cleared.
- Reset mid-operation: asynchronous return to IDLE; all state is cleared; DOUT=0; no irq.
- DOUT holds its value until the next completion.

Test Plan:
- W=16, key=0, DIN=0x00000000, R=1, enc, start -> one cycle later DOUT=0x0123107F, done=1, busy high exactly 1 cycle.
- Same key, R=1, dec with DIN=0x0123107F -> DOUT=0x00000000.
- Random key and DIN, R from 1 to 32, enc, then dec of the result with the same R -> DOUT equals the original DIN in every case; busy high exactly R cycles each run.
- R=0, DIN=0x41424344 -> DOUT=0x41424344, done=1, busy never asserted.
- Start with R=20, then write KEY_LO=0xFFFFFFFF at cycle 5 -> pslverr=1, err=1, KEY_LO unchanged, result matches the original key; W1C 0x4 clears err.
- ien=1, R=8 run -> irq rises with done and falls on a STATUS write of 0x2.
- Second run: deassert prstb at cycle 3 -> busy=0, DOUT=0, irq=0 immediately; a new start after release completes correctly.

Source files
------------

// File: rtl/tea_cipher_apb.sv
// rtl/tea_cipher_apb.sv - APB-programmable iterative TEA encrypt/decrypt engine
// One round per pclk; both half-updates of a round are chained combinationally.
module tea_cipher_apb #(
  parameter int          W     = 16,
  parameter logic [15:0] DELTA = 16'h0123,
  parameter int          SHL   = 4,
  parameter int          SHR   = 5,
  parameter int          RW    = 8
) (
  input  logic        pclk,
  input  logic        prstb,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [W-1:0] DELTA_W = DELTA[W-1:0];

  logic [1:0]     state_q, state_d;
  logic [63:0]    key_q, key_d;
  logic [2*W-1:0] din_q, din_d, dout_q, dout_d;
  logic [RW-1:0]  rounds_q, rounds_d, cnt_q, cnt_d;
  logic           mode_q, mode_d, ien_q, ien_d, done_q, done_d, err_q, err_d;
  logic [W-1:0]   v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;

  function automatic logic [W-1:0] rf(input logic [W-1:0] x, input logic [W-1:0] ka,
                                      input logic [W-1:0] kb, input logic [W-1:0] s);
    return ((x << SHL) + ka) ^ (x + s) ^ ((x >> SHR) + kb);
  endfunction

  logic [W-1:0] k0, k1, k2, k3;
  assign k0 = key_q[4*W-1:3*W];
  assign k1 = key_q[3*W-1:2*W];
  assign k2 = key_q[2*W-1:W];
  assign k3 = key_q[W-1:0];

  logic [W-1:0] enc_s, enc_v0, enc_v1, dec_v0, dec_v1;
  assign enc_s  = sum_q + DELTA_W;
  assign enc_v0 = v0_q + rf(v1_q, k0, k1, enc_s);
  assign enc_v1 = v1_q + rf(enc_v0, k2, k3, enc_s);
  assign dec_v1 = v1_q - rf(v0_q, k2, k3, sum_q);
  assign dec_v0 = v0_q - rf(dec_v1, k0, k1, sum_q);

  logic [2:0] idx;
  logic       acc, wr, busy, mapped, locked, start_go;
  logic       unused_paddr;
  assign idx     = paddr[4:2];
  assign acc     = psel & penable;
  assign wr      = acc & pwrite;
  assign busy    = (state_q == S_RUN);
  assign mapped  = (idx <= 3'd5);
  // Key, block and control registers are frozen while a run is in flight.
  assign locked  = busy & (idx <= 3'd3);
  assign pslverr = acc & (~mapped | (pwrite & locked));
  assign pready  = 1'b1;
  assign irq     = done_q & ien_q;
  assign unused_paddr = ^{paddr[31:5], paddr[1:0]};

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    din_d    = din_q;
    dout_d   = dout_q;
    rounds_d = rounds_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    ien_d    = ien_q;
    done_d   = done_q;
    err_d    = err_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    sum_d    = sum_q;
    start_go = 1'b0;

    if (wr && mapped) begin
      if (locked) begin
        err_d = 1'b1;
        if (idx == 3'd3) ien_d = pwdata[RW+2];
      end else begin
        case (idx)
          3'd0: key_d[31:0] = pwdata;
          3'd1: if (W == 16) key_d[63:32] = pwdata;
          3'd2: din_d = pwdata[2*W-1:0];
          3'd3: begin
            rounds_d = pwdata[RW-1:0];
            mode_d   = pwdata[RW];
            start_go = pwdata[RW+1];
            ien_d    = pwdata[RW+2];
          end
          3'd5: begin
            if (pwdata[1]) done_d = 1'b0;
            if (pwdata[2]) err_d  = 1'b0;
          end
          default: ;
        endcase
      end
    end

    // Completion is applied after the W1C so a same-edge clear of done loses.
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_go) begin
          if (rounds_d != '0) begin
            v0_d    = din_q[2*W-1:W];
            v1_d    = din_q[W-1:0];
            sum_d   = mode_d ? W'(DELTA_W * W'(rounds_d)) : '0;
            cnt_d   = rounds_d;
            state_d = S_RUN;
          end else begin
            dout_d = din_q;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        v0_d  = mode_q ? dec_v0 : enc_v0;
        v1_d  = mode_q ? dec_v1 : enc_v1;
        sum_d = mode_q ? (sum_q - DELTA_W) : enc_s;
        if (cnt_q == {{(RW-1){1'b0}}, 1'b1}) begin
          dout_d  = {v0_d, v1_d};
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prstb) begin
    if (!prstb) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      rounds_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      ien_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      v0_q     <= '0;
      v1_q     <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      rounds_q <= rounds_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      ien_q    <= ien_d;
      done_q   <= done_d;
      err_q    <= err_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      sum_q    <= sum_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (psel) begin
      case (idx)
        3'd0: prdata = key_q[31:0];
        3'd1: if (W == 16) prdata = key_q[63:32];
        3'd2: prdata[2*W-1:0] = din_q;
        3'd3: prdata[RW+2:0] = {ien_q, 1'b0, mode_q, rounds_q};
        3'd4: prdata[2*W-1:0] = dout_q;
        3'd5: prdata[2:0] = {err_q, done_q, busy};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_cipher_apb.sv
// tb/tb_tea_cipher_apb.sv - directed bench for tea_cipher_apb with a functional TEA model
module tb_tea_cipher_apb;

  logic        pclk, prstb, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr, irq;

  tea_cipher_apb dut (
    .pclk(pclk), .prstb(prstb), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq)
  );

  localparam logic [31:0] START = 32'h200, DEC = 32'h100, IEN = 32'h400;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  function automatic logic [15:0] f16(input logic [15:0] x, input logic [15:0] ka,
                                      input logic [15:0] kb, input logic [15:0] s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  function automatic logic [31:0] tea_enc(input logic [63:0] k, input logic [31:0] b, input int r);
    logic [15:0] v0, v1, s;
    v0 = b[31:16]; v1 = b[15:0]; s = 16'h0;
    for (int i = 0; i < r; i++) begin
      s  = s + 16'h0123;
      v0 = v0 + f16(v1, k[63:48], k[47:32], s);
      v1 = v1 + f16(v0, k[31:16], k[15:0], s);
    end
    return {v0, v1};
  endfunction

  function automatic logic [31:0] tea_dec(input logic [63:0] k, input logic [31:0] b, input int r);
    logic [15:0] v0, v1, s;
    v0 = b[31:16]; v1 = b[15:0]; s = 16'(32'(r) * 32'h0123);
    for (int i = 0; i < r; i++) begin
      v1 = v1 - f16(v0, k[31:16], k[15:0], s);
      v0 = v0 - f16(v1, k[63:48], k[47:32], s);
      s  = s - 16'h0123;
    end
    return {v0, v1};
  endfunction

  // Register-level model: remaining rounds as a plain countdown, result precomputed at start.
  logic [63:0] m_key;
  logic [31:0] m_din, m_dout, m_res;
  logic [7:0]  m_r;
  logic        m_mode, m_ien, m_done, m_err;
  int          m_left;

  always @(posedge pclk or negedge prstb) begin : mdl
    int   ix;
    logic bn, go;
    if (!prstb) begin
      m_key = '0; m_din = '0; m_dout = '0; m_res = '0; m_r = '0;
      m_mode = 0; m_ien = 0; m_done = 0; m_err = 0; m_left = 0;
    end else begin
      bn = (m_left > 0);
      go = 1'b0;
      if (psel && penable && pwrite) begin
        ix = int'(paddr[4:2]);
        if (bn && ix <= 3) begin
          m_err = 1'b1;
          if (ix == 3) m_ien = pwdata[10];
        end else begin
          case (ix)
            0: m_key[31:0]  = pwdata;
            1: m_key[63:32] = pwdata;
            2: m_din        = pwdata;
            3: begin m_r = pwdata[7:0]; m_mode = pwdata[8]; go = pwdata[9]; m_ien = pwdata[10]; end
            5: begin if (pwdata[1]) m_done = 1'b0; if (pwdata[2]) m_err = 1'b0; end
            default: ;
          endcase
        end
      end
      if (bn) begin
        m_left--;
        if (m_left == 0) begin m_dout = m_res; m_done = 1'b1; end
      end
      if (go) begin
        if (m_r == 0) begin
          m_dout = m_din; m_done = 1'b1;
        end else begin
          m_left = int'(m_r);
          m_res  = m_mode ? tea_dec(m_key, m_din, int'(m_r)) : tea_enc(m_key, m_din, int'(m_r));
        end
      end
    end
  end

  function automatic logic [31:0] model_read(input int ix);
    case (ix)
      0: return m_key[31:0];
      1: return m_key[63:32];
      2: return m_din;
      3: return {21'b0, m_ien, 1'b0, m_mode, m_r};
      4: return m_dout;
      5: return {29'b0, m_err, m_done, (m_left > 0)};
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge pclk) begin
    if (cmp_en) begin
      chk("irq", {31'b0, irq}, {31'b0, m_done & m_ien});
      if (psel && penable) begin
        chk("pslverr", {31'b0, pslverr},
            {31'b0, (paddr[4:2] > 3'd5) || (pwrite && paddr[4:2] <= 3'd3 && m_left > 0)});
        if (!pwrite) chk("prdata", prdata, model_read(int'(paddr[4:2])));
      end
    end
  end

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge pclk); #1 penable = 1;
    #3 e = pslverr;
    @(posedge pclk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge pclk); #1 penable = 1;
    #3 d = prdata; e = pslverr;
    @(posedge pclk); #1 psel = 0; penable = 0;
  endtask

  task automatic load(input logic [63:0] k, input logic [31:0] b);
    logic e;
    apb_write(32'h00, k[31:0], e);
    apb_write(32'h04, k[63:32], e);
    apb_write(32'h08, b, e);
  endtask

  // Start a run, then hold a back-to-back STATUS read to count busy cycles until done.
  task automatic run_op(input logic [31:0] ctrl, output int busy_cnt);
    logic e, seen;
    apb_write(32'h14, 32'h2, e);
    @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = ctrl;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 pwrite = 0; paddr = 32'h14;
    busy_cnt = 0; seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge pclk);
      if (prdata[0]) busy_cnt++;
      if (prdata[1]) seen = 1;
    end
    chk("run_done_seen", {31'b0, seen}, 32'h1);
    @(posedge pclk); #1 psel = 0; penable = 0;
  endtask

  initial begin : main
    logic [31:0] d, c, din;
    logic [63:0] key;
    logic        e, seen;
    int          bc;
    int          rl[6];
    rl = '{1, 2, 7, 16, 31, 32};
    #300000;
  end

  initial begin : stim
    logic [31:0] d, c, din;
    logic [63:0] key;
    logic        e, seen;
    int          bc;
    int          rl[6];
    rl = '{1, 2, 7, 16, 31, 32};
    prstb = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    repeat (3) @(posedge pclk);
    #1 chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    prstb = 1; cmp_en = 1;
    for (int i = 0; i < 6; i++) begin
      apb_read(32'(i * 4), d, e);
      chk("rst_reg", d, 32'h0);
    end
    apb_read(32'h18, d, e);
    chk("unmapped_err", {31'b0, e}, 32'h1);
    chk("unmapped_data", d, 32'h0);

    // key=0, DIN=0, one encryption round
    run_op(START | 32'd1, bc);
    chk("enc1_busy", bc, 1);
    apb_read(32'h10, d, e);
    chk("enc1_dout", d, 32'h0123107F);
    apb_read(32'h14, d, e);
    chk("enc1_status", d, 32'h2);

    load(64'h0, 32'h0123107F);
    run_op(START | DEC | 32'd1, bc);
    apb_read(32'h10, d, e);
    chk("dec1_dout", d, 32'h0);

    for (int i = 0; i < 6; i++) begin
      key = {$urandom, $urandom};
      din = $urandom;
      load(key, din);
      run_op(START | 32'(rl[i]), bc);
      chk("enc_busy", bc, rl[i]);
      apb_read(32'h10, c, e);
      chk("enc_result", c, tea_enc(key, din, rl[i]));
      apb_write(32'h08, c, e);
      run_op(START | DEC | 32'(rl[i]), bc);
      chk("dec_busy", bc, rl[i]);
      apb_read(32'h10, d, e);
      chk("roundtrip", d, din);
    end

    apb_write(32'h08, 32'h41424344, e);
    run_op(START, bc);
    chk("r0_busy", bc, 0);
    apb_read(32'h10, d, e);
    chk("r0_dout", d, 32'h41424344);

    // write to a locked register mid-run
    key = 64'h0F1E2D3C_4B5A6978;
    din = 32'hCAFEF00D;
    load(key, din);
    apb_write(32'h14, 32'h6, e);
    apb_write(32'h0C, START | 32'd20, e);
    repeat (2) @(posedge pclk);
    apb_write(32'h00, 32'hFFFFFFFF, e);
    chk("locked_slverr", {31'b0, e}, 32'h1);
    apb_read(32'h14, d, e);
    chk("locked_err_busy", d & 32'h5, 32'h5);
    seen = 0;
    for (int c2 = 0; c2 < 40 && !seen; c2++) begin
      apb_read(32'h14, d, e);
      seen = d[1];
    end
    chk("locked_done_seen", {31'b0, seen}, 32'h1);
    apb_read(32'h00, d, e);
    chk("key_lo_kept", d, key[31:0]);
    apb_read(32'h10, d, e);
    chk("locked_result", d, tea_enc(key, din, 20));
    apb_write(32'h14, 32'h4, e);
    apb_read(32'h14, d, e);
    chk("err_cleared", d & 32'h4, 32'h0);

    // interrupt follows done
    apb_write(32'h14, 32'h6, e);
    run_op(IEN | START | 32'd8, bc);
    @(negedge pclk);
    chk("irq_high", {31'b0, irq}, 32'h1);
    apb_write(32'h14, 32'h2, e);
    @(negedge pclk);
    chk("irq_low", {31'b0, irq}, 32'h0);

    // asynchronous reset in the middle of a run
    apb_write(32'h0C, IEN | START | 32'd20, e);
    repeat (2) @(posedge pclk);
    #2 prstb = 0;
    #1 chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    psel = 1; penable = 1; pwrite = 0; paddr = 32'h10;
    #1 chk("mid_rst_dout", prdata, 32'h0);
    paddr = 32'h14;
    #1 chk("mid_rst_status", prdata, 32'h0);
    @(posedge pclk); #1 prstb = 1; psel = 0; penable = 0;
    key = 64'h01234567_89ABCDEF;
    din = 32'h13579BDF;
    load(key, din);
    run_op(START | 32'd5, bc);
    chk("post_rst_busy", bc, 5);
    apb_read(32'h10, d, e);
    chk("post_rst_result", d, tea_enc(key, din, 5));

    repeat (2) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
